// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and the mux/ALU select codes used by the controller, datapath and ALU decoder.
package riscv_ctrl_pkg;

    // Controller states; FETCH must stay at code 0 (reset and debug value).
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecute  = 4'd2,
        StAluWb    = 4'd3,
        StMemAddr  = 4'd4,
        StMemRead  = 4'd5,
        StMemWrite = 4'd6,
        StMemWb    = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StTrap     = 4'd10
    } ctrl_state_t;

    // Supported major opcodes (instruction[6:0]).
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    // ALU operation class handed to the ALU decoder.
    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpFunct  = 2'b10;
    localparam logic [1:0] AluOpPass   = 2'b11;

    // ALU operand A select.
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    // ALU operand B select.
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    // Register file writeback source.
    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMdr    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

    // State that follows DECODE for a given opcode; unknown opcodes trap.
    function automatic ctrl_state_t decode_next(input logic [6:0] opcode);
        ctrl_state_t nxt;
        unique case (opcode)
            OpRType, OpIType, OpLui, OpAuipc: nxt = StExecute;
            OpLoad, OpStore:                  nxt = StMemAddr;
            OpBranch:                         nxt = StBranch;
            OpJal, OpJalr:                    nxt = StJump;
            default:                          nxt = StTrap;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath strobes.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       BrTaken,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] MemToReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state_o
);

    ctrl_state_t state_q, state_d;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; everything defaults to idle/0.
    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = WbAluOut;
        ALUSrcA    = SrcAPc;
        ALUSrcB    = SrcBRs2;
        ALUOp      = AluOpAdd;
        instr_done = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC + 4 computed in parallel with the instruction read.
                MemRead = 1'b1;
                IorD    = 1'b0;
                ALUSrcA = SrcAPc;
                ALUSrcB = SrcBFour;
                ALUOp   = AluOpAdd;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = 1'b0;
                    state_d = StDecode;
                end
            end

            StDecode: begin
                // OldPC + imm lands in ALUOut as the branch/JAL target.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                ALUOp   = AluOpAdd;
                state_d = decode_next(Opcode);
            end

            StExecute: begin
                case (Opcode)
                    OpRType: begin
                        ALUSrcA = SrcARs1;
                        ALUSrcB = SrcBRs2;
                        ALUOp   = AluOpFunct;
                    end
                    OpIType: begin
                        ALUSrcA = SrcARs1;
                        ALUSrcB = SrcBImm;
                        ALUOp   = AluOpFunct;
                    end
                    OpLui: begin
                        ALUSrcA = SrcAZero;
                        ALUSrcB = SrcBImm;
                        ALUOp   = AluOpPass;
                    end
                    OpAuipc: begin
                        ALUSrcA = SrcAOldPc;
                        ALUSrcB = SrcBImm;
                        ALUOp   = AluOpAdd;
                    end
                    default: ;
                endcase
                state_d = StAluWb;
            end

            StAluWb: begin
                RegWrite   = 1'b1;
                MemToReg   = WbAluOut;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StMemAddr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                ALUOp   = AluOpAdd;
                state_d = (Opcode == OpStore) ? StMemWrite : StMemRead;
            end

            StMemRead: begin
                // Request held steady until the memory accepts it.
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end

            StMemWrite: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end

            StMemWb: begin
                RegWrite   = 1'b1;
                MemToReg   = WbMdr;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StBranch: begin
                // Comparator runs on rs1/rs2; target was precomputed in DECODE.
                ALUSrcA    = SrcARs1;
                ALUSrcB    = SrcBRs2;
                ALUOp      = AluOpBranch;
                PCSrc      = 1'b1;
                PCWrite    = BrTaken;
                instr_done = 1'b1;
                state_d    = StFetch;
            end

            StJump: begin
                // PC already holds PC+4, so the link value comes straight from it.
                RegWrite   = 1'b1;
                MemToReg   = WbPc;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                if (Opcode == OpJalr) begin
                    ALUSrcA = SrcARs1;
                    ALUSrcB = SrcBImm;
                    ALUOp   = AluOpAdd;
                    PCSrc   = 1'b0;
                end else begin
                    PCSrc = 1'b1;
                end
                state_d = StFetch;
            end

            StTrap: begin
                // Sticky: only reset leaves this state.
                illegal = 1'b1;
                state_d = StTrap;
            end

            default: begin
                state_d = StFetch;
            end
        endcase

        // Reset kills every strobe in the same cycle so an aborted
        // instruction cannot commit anything.
        if (reset) begin
            PCWrite    = 1'b0;
            PCSrc      = 1'b0;
            IRWrite    = 1'b0;
            IorD       = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            MemToReg   = WbAluOut;
            ALUSrcA    = SrcAPc;
            ALUSrcB    = SrcBRs2;
            ALUOp      = AluOpAdd;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

    // Debug view of the state; reads FETCH while reset is held.
    always_comb begin
        state_o = reset ? 4'd0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: one record per clock
// cycle holding the inputs and the hand-computed outputs for that cycle.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk;
    logic       reset;
    logic [6:0] Opcode;
    logic       BrTaken;
    logic       mem_ready;
    logic       PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite;
    logic [1:0] MemToReg, ALUSrcA, ALUSrcB, ALUOp;
    logic       instr_done, illegal;
    logic [3:0] state_o;

    int tests_run;
    int tests_failed;

    multicycle_controller dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .BrTaken   (BrTaken),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .IRWrite   (IRWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .RegWrite  (RegWrite),
        .MemToReg  (MemToReg),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .instr_done(instr_done),
        .illegal   (illegal),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed expected view:
    // {state[4], pcw, pcsrc, irw, iord, mr, mw, rw, m2r[2], asa[2], asb[2], aop[2], done, ill}
    typedef struct packed {
        logic        rst;
        logic [6:0]  op;
        logic        br;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [20:0] actual_view();
        return {state_o, PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite,
                MemToReg, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal};
    endfunction

    task automatic row(input int rst, input logic [6:0] op, input int br, input int rdy,
                       input int st, input int pcw, input int pcsrc, input int irw,
                       input int iord, input int mr, input int mw, input int rw,
                       input int m2r, input int asa, input int asb, input int aop,
                       input int done, input int ill);
        vec_t v;
        v.rst = 1'(rst);
        v.op  = op;
        v.br  = 1'(br);
        v.rdy = 1'(rdy);
        v.exp = {4'(st), 1'(pcw), 1'(pcsrc), 1'(irw), 1'(iord), 1'(mr), 1'(mw), 1'(rw),
                 2'(m2r), 2'(asa), 2'(asb), 2'(aop), 1'(done), 1'(ill)};
        vecs.push_back(v);
    endtask

    task automatic reset_row();
        row(1, 7'd0, 0, 1,  0, 0,0,0,0,0,0,0, 0,0,0,0, 0,0);
    endtask
    task automatic fetch_ok(input logic [6:0] op);
        row(0, op, 0, 1,    0, 1,0,1,0,1,0,0, 0,0,1,0, 0,0);
    endtask
    task automatic fetch_wait(input logic [6:0] op);
        row(0, op, 0, 0,    0, 0,0,0,0,1,0,0, 0,0,1,0, 0,0);
    endtask
    task automatic decode(input logic [6:0] op);
        row(0, op, 0, 1,    1, 0,0,0,0,0,0,0, 0,1,2,0, 0,0);
    endtask
    task automatic aluwb(input logic [6:0] op);
        row(0, op, 0, 1,    3, 0,0,0,0,0,0,1, 0,0,0,0, 1,0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int memread_cycles;
        int done_count;
        int cycles;
        int waits;
        bit saw_memwb;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        Opcode       = 7'd0;
        BrTaken      = 1'b0;
        mem_ready    = 1'b1;

        // Reset held 3 cycles
        reset_row(); reset_row(); reset_row();
        // R-type with a one-cycle fetch stall up front
        fetch_wait(OP_R);
        fetch_ok(OP_R); decode(OP_R);
        row(0, OP_R, 0, 1,      2, 0,0,0,0,0,0,0, 0,2,0,2, 0,0);
        aluwb(OP_R);
        // I-type
        fetch_ok(OP_I); decode(OP_I);
        row(0, OP_I, 0, 1,      2, 0,0,0,0,0,0,0, 0,2,2,2, 0,0);
        aluwb(OP_I);
        // LUI
        fetch_ok(OP_LUI); decode(OP_LUI);
        row(0, OP_LUI, 0, 1,    2, 0,0,0,0,0,0,0, 0,3,2,3, 0,0);
        aluwb(OP_LUI);
        // AUIPC
        fetch_ok(OP_AUIPC); decode(OP_AUIPC);
        row(0, OP_AUIPC, 0, 1,  2, 0,0,0,0,0,0,0, 0,1,2,0, 0,0);
        aluwb(OP_AUIPC);
        // Load with 2 wait cycles in MEMREAD: 7 cycles total
        fetch_ok(OP_LOAD); decode(OP_LOAD);
        row(0, OP_LOAD, 0, 1,   4, 0,0,0,0,0,0,0, 0,2,2,0, 0,0);
        row(0, OP_LOAD, 0, 0,   5, 0,0,0,1,1,0,0, 0,0,0,0, 0,0);
        row(0, OP_LOAD, 0, 0,   5, 0,0,0,1,1,0,0, 0,0,0,0, 0,0);
        row(0, OP_LOAD, 0, 1,   5, 0,0,0,1,1,0,0, 0,0,0,0, 0,0);
        row(0, OP_LOAD, 0, 1,   7, 0,0,0,0,0,0,1, 1,0,0,0, 1,0);
        // Store with 1 wait cycle
        fetch_ok(OP_STORE); decode(OP_STORE);
        row(0, OP_STORE, 0, 1,  4, 0,0,0,0,0,0,0, 0,2,2,0, 0,0);
        row(0, OP_STORE, 0, 0,  6, 0,0,0,1,0,1,0, 0,0,0,0, 0,0);
        row(0, OP_STORE, 0, 1,  6, 0,0,0,1,0,1,0, 0,0,0,0, 1,0);
        // Branch not taken, then taken
        fetch_ok(OP_BRANCH); decode(OP_BRANCH);
        row(0, OP_BRANCH, 0, 1, 8, 0,1,0,0,0,0,0, 0,2,0,1, 1,0);
        fetch_ok(OP_BRANCH); decode(OP_BRANCH);
        row(0, OP_BRANCH, 1, 1, 8, 1,1,0,0,0,0,0, 0,2,0,1, 1,0);
        // JAL then JALR
        fetch_ok(OP_JAL); decode(OP_JAL);
        row(0, OP_JAL, 0, 1,    9, 1,1,0,0,0,0,1, 2,0,0,0, 1,0);
        fetch_ok(OP_JALR); decode(OP_JALR);
        row(0, OP_JALR, 0, 1,   9, 1,0,0,0,0,0,1, 2,2,2,0, 1,0);
        // Reset mid-instruction (in EXECUTE) aborts with no strobes
        fetch_ok(OP_R); decode(OP_R);
        reset_row();
        fetch_ok(OP_R);
        decode(OP_R);
        row(0, OP_R, 0, 1,      2, 0,0,0,0,0,0,0, 0,2,0,2, 0,0);
        aluwb(OP_R);
        // Illegal opcode: sticky TRAP for 10 cycles, then reset recovers
        fetch_ok(OP_BAD); decode(OP_BAD);
        for (int i = 0; i < 10; i++) begin
            row(0, (i % 2 == 0) ? OP_BAD : OP_JAL, i % 2, (i + 1) % 2,
                10, 0,0,0,0,0,0,0, 0,0,0,0, 0,1);
        end
        reset_row();
        fetch_ok(OP_R);

        // Apply the table: drive on negedge, sample mid-low-phase.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            Opcode    = vecs[i].op;
            BrTaken   = vecs[i].br;
            mem_ready = vecs[i].rdy;
            #2;
            check($sformatf("vec%0d", i), 32'(actual_view()), 32'(vecs[i].exp));
        end

        // Hand-written: load with 5 MEMREAD wait cycles, bounded wait for MEMWB.
        @(negedge clk);
        reset     = 1'b1;
        Opcode    = OP_LOAD;
        BrTaken   = 1'b0;
        mem_ready = 1'b1;
        memread_cycles = 0;
        done_count     = 0;
        cycles         = 0;
        waits          = 0;
        saw_memwb      = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40 && !saw_memwb; c++) begin
            if (c != 0) @(negedge clk);
            if (state_o == 4'd5 && waits < 5) begin
                mem_ready = 1'b0;
                waits++;
            end else begin
                mem_ready = 1'b1;
            end
            #2;
            cycles++;
            if (instr_done) done_count++;
            if (state_o == 4'd5) begin
                memread_cycles++;
                check("memread_req_stable", {30'd0, MemRead, IorD}, 32'd3);
            end
            if (state_o == 4'd7) saw_memwb = 1'b1;
        end
        check("load_reached_memwb", 32'(saw_memwb), 32'd1);
        check("load_memread_cycles", 32'(memread_cycles), 32'd6);
        check("load_total_cycles", 32'(cycles), 32'd10);
        check("load_done_once", 32'(done_count), 32'd1);
        @(negedge clk);
        #2;
        check("load_back_to_fetch", 32'(state_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing FSM for the multi-cycle RV32I datapath. Walks each instruction through fetch, decode, execute, memory and writeback, and drives every datapath strobe and mux select. It also generates the 2-bit `ALUOp` consumed by the ALU decoder, which turns `ALUOp`, `Funct3` and `Funct7` into the 4-bit ALU operation. Memory accesses use a ready handshake, so variable-latency instruction and data memory are tolerated.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Opcode` in 7: `instruction[6:0]` from the instruction register; valid from DECODE onward.
- `BrTaken` in 1: branch-condition result from the datapath comparator.
- `mem_ready` in 1: memory has completed the current request this cycle.
- `PCWrite` out 1: PC register load enable.
- `PCSrc` out 1: PC source select. 0 = live ALU result, 1 = `ALUOut` register.
- `IRWrite` out 1: instruction register and OldPC load enable.
- `IorD` out 1: memory address select. 0 = PC, 1 = `ALUOut`.
- `MemRead` out 1: memory read request.
- `MemWrite` out 1: memory write request.
- `RegWrite` out 1: register file write enable.
- `MemToReg` out 2: writeback source. 00 = `ALUOut`, 01 = MDR, 10 = PC (already PC+4).
- `ALUSrcA` out 2: ALU operand A. 00 = PC, 01 = OldPC, 10 = rs1 register, 11 = zero.
- `ALUSrcB` out 2: ALU operand B. 00 = rs2 register, 01 = constant 4, 10 = immediate.
- `ALUOp` out 2: ALU operation class. 00 = add (LW/SW/AUIPC), 01 = branch compare, 10 = R/I-type, 11 = LUI pass.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: an unsupported opcode was decoded.
- `state_o` out 4: current state encoding, for debug.

## Operation
- Outputs are decoded combinationally from the state register. Exceptions: `PCWrite`/`IRWrite` in FETCH are gated by `mem_ready`, and `PCWrite` in BRANCH is gated by `BrTaken`.
- Any output not listed for a state is 0.
- States and transitions:
  - FETCH:
    - Always: `MemRead`=1, `IorD`=0, `ALUSrcA`=00, `ALUSrcB`=01, `ALUOp`=00.
    - If `mem_ready`: `IRWrite`=1, `PCWrite`=1, `PCSrc`=0, then go to DECODE. Otherwise hold in FETCH.
  - DECODE:
    - Outputs: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00. This precomputes the branch/JAL target into `ALUOut`.
    - Next state by opcode:
      - 0110011, 0010011, 0110111, 0010111 → EXECUTE.
      - 0000011, 0100011 → MEMADDR.
      - 1100011 → BRANCH.
      - 1101111, 1100111 → JUMP.
      - Any other opcode → TRAP.
  - EXECUTE:
    - R-type: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
    - I-type: `ALUSrcA`=10, `ALUSrcB`=10, `ALUOp`=10.
    - LUI: `ALUSrcA`=11, `ALUSrcB`=10, `ALUOp`=11.
    - AUIPC: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00.
    - Next state: ALUWB.
  - ALUWB: `RegWrite`=1, `MemToReg`=00, `instr_done`=1 → FETCH.
  - MEMADDR: `ALUSrcA`=10, `ALUSrcB`=10, `ALUOp`=00. Load → MEMREAD, store → MEMWRITE.
  - MEMREAD: `MemRead`=1, `IorD`=1. Hold until `mem_ready`, then → MEMWB.
  - MEMWRITE: `MemWrite`=1, `IorD`=1. Hold until `mem_ready`; on `mem_ready`, `instr_done`=1 → FETCH.
  - MEMWB: `RegWrite`=1, `MemToReg`=01, `instr_done`=1 → FETCH.
  - BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `PCSrc`=1, `PCWrite`=`BrTaken`, `instr_done`=1 → FETCH.
  - JUMP:
    - Common: `RegWrite`=1, `MemToReg`=10, `PCWrite`=1, `instr_done`=1 → FETCH.
    - JAL: `PCSrc`=1.
    - JALR: `ALUSrcA`=10, `ALUSrcB`=10, `ALUOp`=00, `PCSrc`=0. The datapath clears the target LSB.
  - TRAP: `illegal`=1 and all strobes 0. Sticky until `reset`.
- Request signals (`MemRead`, `MemWrite`, `IorD`) stay stable while waiting for `mem_ready`. No request is dropped or re-issued.
- `Opcode` is sampled live from the instruction register; the IR does not change between DECODE and FETCH.

## Timing
- Reset:
  - While `reset`=1, every output is 0 and `state_o` = FETCH code (0).
  - The first fetch request is issued in the cycle after `reset` deasserts.
  - `reset` asserted mid-instruction aborts it at the next edge. No `RegWrite`, `MemWrite` or `PCWrite` occurs in that cycle.
- Latency in cycles, assuming `mem_ready` on the first request cycle; each memory wait cycle adds 1:
  - R/I/LUI/AUIPC: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - JAL/JALR: 3.
- `mem_ready` high outside FETCH/MEMREAD/MEMWRITE is ignored.
- `instr_done` fires exactly once per retired instruction and never in TRAP.

## Structure
- Shared package `riscv_ctrl_pkg`:
  - `ctrl_state_t` enum (4-bit; FETCH = 0).
  - Opcode localparams.
  - `ALUOp`, `ALUSrcA`, `ALUSrcB`, `MemToReg` encodings, reused by the datapath and the ALU decoder.
- Single module, no sub-modules.
- Implementation: `always_ff` state register plus an `always_comb` next-state/output block with defaults assigned first.

## Test plan
- Reset held 3 cycles, then released with `mem_ready`=1 → all outputs 0 during reset. FETCH follows with `MemRead`=1, `PCWrite`=`IRWrite`=1.
- `Opcode`=0110011, `mem_ready`=1 → state sequence FETCH, DECODE, EXECUTE (`ALUOp`=10, `ALUSrcB`=00), ALUWB (`RegWrite`=1). `instr_done` pulses at cycle 4.
- Load with `mem_ready` low for 2 cycles in MEMREAD → MEMREAD held 3 cycles with `IorD`=1 stable, then MEMWB with `MemToReg`=01. Total 7 cycles.
- Branch (1100011) with `BrTaken`=0, then a second branch with `BrTaken`=1 → `PCWrite`=0 and 1 respectively in BRANCH, `PCSrc`=1, `ALUOp`=01.
- JAL vs JALR → JUMP with `MemToReg`=10 and `PCWrite`=1 in both. `PCSrc`=1 for JAL; `PCSrc`=0 with `ALUSrcA`=10 for JALR.
- `Opcode`=1111111 → TRAP with `illegal`=1, held for 10 cycles with no strobes. `reset` pulse → back to FETCH with `illegal`=0.
